asic_aoi211_bist: RTL and testbench
===================================

// Module: asic_aoi211_bist
// PURPOSE
//  Self-test stage wrapped around one asic_aoi211 cell. It drives all 16 input vectors
//  from flops, samples z after a settle window and checks it against a built-in golden
//  function. It counts mismatches, records the first failing vector and compacts z into
//  a MISR signature. Used for per-PROP cell characterisation and silicon bring-up.
// PARAMETERS
//  PROP    "DEFAULT"  cell property string, passed unchanged to the asic_aoi211 instance
//  PASSES  1          full 16-vector sweeps per run (1..255)
//  SETTLE  1          cycles between applying a vector and sampling z (1..15)
// PORTS
//  clk         in   1  single clock
//  nreset      in   1  asynchronous active-low reset
//  start       in   1  run request, sampled only in IDLE
//  inj_en      in   1  fault injection enable; inverts sampled z when vec==inj_vec
//  inj_vec     in   4  vector to corrupt when inj_en=1
//  busy        out  1  run in progress
//  done        out  1  one-cycle pulse at end of run
//  pass        out  1  1 = last run had zero mismatches; valid while done/IDLE
//  fail_count  out  8  saturating mismatch count of last run
//  first_fail  out  4  first mismatching vector of last run (0 if none)
//  signature   out  8  MISR value of last run
// BEHAVIOUR
//  Reset (async, nreset=0): state=IDLE, cell inputs=0, busy=0, done=0, pass=0,
//   fail_count=0, first_fail=0, signature=8'hFF; settle/vector/pass counters=0.
//  Vector map: {a0,a1,b0,c0} = vec[3:0]; expected z = ~((a0&a1)|b0|c0).
//   Expected z=1 only for vec 0,4,8.
//  FSM IDLE -> APPLY -> SAMPLE -> {APPLY | DONE} -> IDLE:
//   IDLE: start=1 clears fail_count/first_fail/pass, seeds signature=8'hFF, vec=0,
//    pass_cnt=0, busy<=1, goes to APPLY. start=0 keeps IDLE.
//   APPLY: cell inputs driven from vec flops; stays SETTLE cycles (settle counter).
//   SAMPLE (1 cycle): zs = z ^ (inj_en & vec==inj_vec); compare zs to expected.
//    On mismatch: fail_count+1 (saturates at 8'hFF); first_fail<=vec if fail_count==0.
//    MISR: signature <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {7'b0, zs}.
//    vec<15: vec+1 -> APPLY. vec==15 and pass_cnt<PASSES-1: vec wraps to 0, pass_cnt+1,
//    -> APPLY. Otherwise -> DONE.
//   DONE (1 cycle): done=1, busy<=0, pass<=(fail_count==0) -> IDLE.
//  Latency: start edge to done high = PASSES*16*(SETTLE+1)+1 cycles.
//  busy rises the cycle after start is accepted.
//  start while busy or in DONE is ignored (no queueing).
//  Results hold until the next accepted start.
//  inj_en/inj_vec are sampled in SAMPLE only; changing them mid-run is legal.
//  Reset mid-run aborts immediately to reset values; no done pulse.
//  z is used only inside SAMPLE, after >=1 full cycle of stable cell inputs.
// STRUCTURE
//  Shared package asic_bist_pkg:
//   - state encoding (IDLE/APPLY/SAMPLE/DONE)
//   - MISR seed 8'hFF and tap mask 8'hB8
//   - aoi211 golden function
//  Sub-modules:
//   - asic_bist_misr (8-bit MISR; load, seed, enable), reusable for other cell BISTs
//   - one asic_aoi211 #(PROP) instance as the cell under test
// TESTING
//  1 PASSES=1,SETTLE=1, pulse start -> done at cycle 33; pass=1, fail_count=0,
//    first_fail=0; signature matches the bench MISR model.
//  2 inj_en=1, inj_vec=4'd5, PASSES=3 -> pass=0, fail_count=3, first_fail=5.
//  3 inj_en=1, inj_vec=4'd12 (expected 0 -> corrupted 1) -> fail_count=1,
//    first_fail=12; signature differs from scenario 1.
//  4 Second start pulse mid-run -> ignored; done exactly once, at the same cycle
//    as scenario 1.
//  5 nreset low for 1 cycle at vector 7 -> all outputs at reset values, busy=0,
//    no done; a new start then completes with pass=1.
//  6 SETTLE=15, PASSES=2 -> done at cycle 513; a0..c0 change only on APPLY entry.

Source files
------------

// File: rtl/asic_bist_pkg.sv
// Shared definitions for single-cell BIST wrappers:
// FSM encoding, MISR constants and the AOI211 golden model.
package asic_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } bist_state_e;

    localparam logic [7:0] MISR_SEED = 8'hFF;
    localparam logic [7:0] MISR_TAPS = 8'hB8;

    // vec = {a0, a1, b0, c0}
    function automatic logic aoi211_golden(input logic [3:0] vec);
        return ~((vec[3] & vec[2]) | vec[1] | vec[0]);
    endfunction

endpackage

// File: rtl/asic_aoi211_bist_if.sv
// Control and result bundle between a BIST controller
// and the block that starts it and collects results.
interface asic_aoi211_bist_if;

    logic       start;
    logic       inj_en;
    logic [3:0] inj_vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_count;
    logic [3:0] first_fail;
    logic [7:0] signature;

    modport master (
        output start, inj_en, inj_vec,
        input  busy, done, pass,
        input  fail_count, first_fail, signature
    );

    modport slave (
        input  start, inj_en, inj_vec,
        output busy, done, pass,
        output fail_count, first_fail, signature
    );

endinterface

// File: rtl/asic_aoi211.sv
// AOI211 cell: z = ~((a0 & a1) | b0 | c0).
// PROP selects the library flavour and does not alter logic.
module asic_aoi211 #(
    parameter PROP = "DEFAULT"
) (
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic c0,
    output logic z
);

    assign z = ~((a0 & a1) | b0 | c0);

endmodule

// File: rtl/asic_bist_misr.sv
// 8-bit serial-input MISR with seed load and shift enable.
// Load has priority over shift.
module asic_bist_misr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       en_i,
    input  logic       d_i,
    output logic [7:0] sig_o
);

    import asic_bist_pkg::*;

    logic [7:0] sig_q;
    logic [7:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = seed_i;
        end else if (en_i) begin
            sig_d = {sig_q[6:0], ^(sig_q & MISR_TAPS)}
                  ^ {7'b0, d_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/asic_aoi211_bist.sv
// Exhaustive self-test around one AOI211 cell: sweeps all
// 16 vectors PASSES times, checks z and compacts it in a MISR.
module asic_aoi211_bist #(
    parameter              PROP   = "DEFAULT",
    parameter int unsigned PASSES = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               nreset,
    asic_aoi211_bist_if.slave  bus
);

    import asic_bist_pkg::*;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    bist_state_e state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [7:0]  fail_q, fail_d;
    logic [3:0]  first_q, first_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic z, zs, mism;
    logic settled, last_vec, last_pass;
    logic misr_load, misr_en;

    // Cell inputs come straight from the vector flops
    asic_aoi211 #(.PROP(PROP)) u_cell (
        .a0 (vec_q[3]),
        .a1 (vec_q[2]),
        .b0 (vec_q[1]),
        .c0 (vec_q[0]),
        .z  (z)
    );

    assign settled   = settle_q == SETTLE_LAST;
    assign last_vec  = vec_q == 4'hF;
    assign last_pass = pcnt_q == PASS_LAST;

    assign zs   = z ^ (bus.inj_en && (vec_q == bus.inj_vec));
    assign mism = zs != aoi211_golden(vec_q);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_APPLY;
            ST_APPLY:  if (settled) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (last_vec && last_pass)
                               ? ST_DONE : ST_APPLY;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_d     = vec_q;
        settle_d  = settle_q;
        pcnt_d    = pcnt_q;
        fail_d    = fail_q;
        first_d   = first_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    vec_d     = '0;
                    settle_d  = '0;
                    pcnt_d    = '0;
                    fail_d    = '0;
                    first_d   = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    misr_load = 1'b1;
                end
            end
            ST_APPLY: begin
                settle_d = settled ? 4'd0 : settle_q + 4'd1;
            end
            ST_SAMPLE: begin
                misr_en = 1'b1;
                if (mism) begin
                    if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
                    if (fail_q == 8'd0)  first_d = vec_q;
                end
                if (!last_vec) begin
                    vec_d = vec_q + 4'd1;
                end else if (!last_pass) begin
                    vec_d  = '0;
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                pass_d = fail_q == 8'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vec_q    <= '0;
            settle_q <= '0;
            pcnt_q   <= '0;
            fail_q   <= '0;
            first_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            pcnt_q   <= pcnt_d;
            fail_q   <= fail_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    asic_bist_misr u_misr (
        .clk    (clk),
        .rst_n  (nreset),
        .load_i (misr_load),
        .seed_i (MISR_SEED),
        .en_i   (misr_en),
        .d_i    (zs),
        .sig_o  (bus.signature)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_count = fail_q;
    assign bus.first_fail = first_q;

endmodule

// File: tb/tb_asic_aoi211_bist.sv
// Bench for asic_aoi211_bist: three parameterisations, table
// rows, random injection runs and a mid-run reset sequence.
module tb_asic_aoi211_bist;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int PASSES_OF[3] = '{1, 3, 2};
    int SETTLE_OF[3] = '{1, 1, 15};

    asic_aoi211_bist_if b0 ();
    asic_aoi211_bist_if b1 ();
    asic_aoi211_bist_if b2 ();

    asic_aoi211_bist #(.PROP("DEFAULT"), .PASSES(1), .SETTLE(1))
    dut0 (.clk(clk), .nreset(nreset), .bus(b0.slave));

    asic_aoi211_bist #(.PROP("HVT"), .PASSES(3), .SETTLE(1))
    dut1 (.clk(clk), .nreset(nreset), .bus(b1.slave));

    asic_aoi211_bist #(.PROP("LVT"), .PASSES(2), .SETTLE(15))
    dut2 (.clk(clk), .nreset(nreset), .bus(b2.slave));

    typedef struct {
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] fc;
        logic [3:0] ff;
        logic [7:0] sig;
    } obs_t;

    typedef struct {
        int         inst;
        logic       ie;
        logic [3:0] iv;
        int         restart_at;
        logic       exp_pass;
        int         exp_fc;
        logic [3:0] exp_ff;
        int         exp_lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic s,
                         input logic ie, input logic [3:0] iv);
        case (k)
            0: begin b0.start = s; b0.inj_en = ie; b0.inj_vec = iv; end
            1: begin b1.start = s; b1.inj_en = ie; b1.inj_vec = iv; end
            default: begin
                b2.start = s; b2.inj_en = ie; b2.inj_vec = iv;
            end
        endcase
    endtask

    function automatic obs_t peek(input int k);
        obs_t o;
        case (k)
            0: begin
                o.busy = b0.busy; o.done = b0.done; o.pass = b0.pass;
                o.fc = b0.fail_count; o.ff = b0.first_fail;
                o.sig = b0.signature;
            end
            1: begin
                o.busy = b1.busy; o.done = b1.done; o.pass = b1.pass;
                o.fc = b1.fail_count; o.ff = b1.first_fail;
                o.sig = b1.signature;
            end
            default: begin
                o.busy = b2.busy; o.done = b2.done; o.pass = b2.pass;
                o.fc = b2.fail_count; o.ff = b2.first_fail;
                o.sig = b2.signature;
            end
        endcase
        return o;
    endfunction

    // Behavioural model: every vector of every sweep, set-based golden
    task automatic model(input int passes, input logic ie,
                         input logic [3:0] iv, output int fc,
                         output logic [3:0] ff, output logic [7:0] sig);
        int fb;
        logic good, flip, zs;
        fc = 0;
        ff = 4'd0;
        sig = 8'hFF;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < 16; v++) begin
                good = (v == 0) || (v == 4) || (v == 8);
                flip = ie && (v == int'(iv));
                zs = good ^ flip;
                if (flip) begin
                    if (fc == 0) ff = v[3:0];
                    if (fc < 255) fc++;
                end
                fb = $countones(sig & 8'hB8) % 2;
                sig = (sig << 1) | 8'(fb);
                sig = sig ^ 8'(zs);
            end
        end
    endtask

    task automatic run(input string tag, input int k,
                       input logic ie, input logic [3:0] iv,
                       input int restart_at, input logic exp_pass,
                       input int exp_fc, input logic [3:0] exp_ff,
                       input int exp_lat, input logic [7:0] exp_sig);
        obs_t o, res;
        int ndone, first;
        logic busy1;
        ndone = 0;
        first = 0;
        busy1 = 1'b0;
        res = peek(k);
        drive(k, 1'b1, ie, iv);
        @(posedge clk); #1;
        for (int c = 1; c <= exp_lat + 3; c++) begin
            drive(k, (restart_at != 0 && c == restart_at), ie, iv);
            @(posedge clk); #1;
            o = peek(k);
            if (c == 1) busy1 = o.busy;
            if (o.done) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    res = o;
                end
            end
        end
        chk({tag, " busy_rise"}, 32'(busy1), 32'd1);
        chk({tag, " latency"}, first, exp_lat);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " busy_fall"}, 32'(res.busy), 32'd0);
        chk({tag, " pass"}, 32'(res.pass), 32'(exp_pass));
        chk({tag, " fail_count"}, 32'(res.fc), exp_fc);
        chk({tag, " first_fail"}, 32'(res.ff), 32'(exp_ff));
        chk({tag, " signature"}, 32'(res.sig), 32'(exp_sig));
        o = peek(k);
        chk({tag, " hold_pass"}, 32'(o.pass), 32'(exp_pass));
    endtask

    task automatic chk_reset(input string tag, input int k);
        obs_t o;
        o = peek(k);
        chk({tag, " busy"}, 32'(o.busy), 32'd0);
        chk({tag, " done"}, 32'(o.done), 32'd0);
        chk({tag, " pass"}, 32'(o.pass), 32'd0);
        chk({tag, " fail_count"}, 32'(o.fc), 32'd0);
        chk({tag, " first_fail"}, 32'(o.ff), 32'd0);
        chk({tag, " signature"}, 32'(o.sig), 32'hFF);
    endtask

    initial begin
        int fc, lat, nd;
        logic [3:0] ff, iv;
        logic [7:0] sig;
        logic ie;
        int k;
        obs_t o;

        tbl[0] = '{0, 1'b0, 4'd0,  0,  1'b1, 0, 4'd0,  33};
        tbl[1] = '{0, 1'b1, 4'd12, 0,  1'b0, 1, 4'd12, 33};
        tbl[2] = '{1, 1'b1, 4'd5,  0,  1'b0, 3, 4'd5,  97};
        tbl[3] = '{0, 1'b0, 4'd0,  10, 1'b1, 0, 4'd0,  33};
        tbl[4] = '{0, 1'b1, 4'd0,  0,  1'b0, 1, 4'd0,  33};
        tbl[5] = '{0, 1'b1, 4'd15, 0,  1'b0, 1, 4'd15, 33};
        tbl[6] = '{2, 1'b0, 4'd0,  0,  1'b1, 0, 4'd0,  513};
        tbl[7] = '{2, 1'b1, 4'd8,  0,  1'b0, 2, 4'd8,  513};

        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_reset($sformatf("rst%0d", i), i);
        nreset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            model(PASSES_OF[tbl[i].inst], tbl[i].ie, tbl[i].iv,
                  fc, ff, sig);
            run($sformatf("tbl%0d", i), tbl[i].inst, tbl[i].ie,
                tbl[i].iv, tbl[i].restart_at, tbl[i].exp_pass,
                tbl[i].exp_fc, tbl[i].exp_ff, tbl[i].exp_lat, sig);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 6; i++) begin
            k = int'($urandom_range(0, 1));
            ie = 1'($urandom % 2);
            iv = 4'($urandom % 16);
            model(PASSES_OF[k], ie, iv, fc, ff, sig);
            lat = PASSES_OF[k] * 16 * (SETTLE_OF[k] + 1) + 1;
            run($sformatf("rnd%0d", i), k, ie, iv, 0, fc == 0,
                fc, ff, lat, sig);
        end

        // Reset during vector 7 with an earlier injected failure
        drive(0, 1'b1, 1'b1, 4'd2);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 4'd2);
        repeat (15) @(posedge clk);
        #1;
        o = peek(0);
        chk("midrun busy", 32'(o.busy), 32'd1);
        chk("midrun fail_count", 32'(o.fc), 32'd1);
        nreset = 1'b0;
        #2;
        chk_reset("abort", 0);
        @(posedge clk); #1;
        nreset = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            o = peek(0);
            if (o.done || o.busy) nd++;
        end
        chk("abort no_done", nd, 0);
        model(1, 1'b0, 4'd0, fc, ff, sig);
        run("after_abort", 0, 1'b0, 4'd0, 0, 1'b1, 0, 4'd0, 33, sig);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
